// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I controller: state encoding,
// opcodes, ALUControlOp codes and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5,
      S_HALT = 3'd6
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_SR = 3'b101;

   localparam logic [2:0] ConOP_ADD    = 3'b000;
   localparam logic [2:0] ConOP_R      = 3'b001;
   localparam logic [2:0] ConOP_R_     = 3'b101;
   localparam logic [2:0] ConOP_I      = 3'b010;
   localparam logic [2:0] ConOP_I_     = 3'b110;
   localparam logic [2:0] ConOP_BRANCH = 3'b011;
   localparam logic [2:0] ConOP_ID     = 3'b111;

   localparam logic [1:0] SRCA_OLDPC = 2'd0;
   localparam logic [1:0] SRCA_RS1   = 2'd1;
   localparam logic [1:0] SRCA_ZERO  = 2'd2;
   localparam logic [1:0] SRCA_PC    = 2'd3;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MDR = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   // Opcodes the controller can execute; everything else (ECALL included) halts.
   function automatic logic is_exec_op(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_sel.sv
// EX-stage ALUControlOp selection from the latched opcode/funct fields.
module alu_op_sel
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7_5,
   output logic [2:0] o_alu_op
);

   always_comb begin
      o_alu_op = ConOP_ADD;
      case (i_opcode)
         OP_R:      o_alu_op = i_funct7_5 ? ConOP_R_ : ConOP_R;
         // funct7_5 only selects SRAI among immediates; for ADDI it is imm bit 10
         OP_I:      o_alu_op = (i_funct3 == F3_SR && i_funct7_5) ? ConOP_I_ : ConOP_I;
         OP_BRANCH: o_alu_op = ConOP_BRANCH;
         OP_LUI:    o_alu_op = ConOP_ID;
         default:   o_alu_op = ConOP_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I controller: IF/ID/EX/MEM/WB sequencing with a memory ready handshake.
// Optional performance counters are enabled with the MC_PERF_CNT_EN macro.
module multicycle_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       Bcond,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] wb_sel,
   output logic       pc_src,
   output logic [2:0] ALUControlOp,
   output logic       halted,
   output logic       bus_err
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
`endif
);

   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t          r_state;
   logic [TO_W-1:0] r_wait_cnt;
   logic            r_halted;
   logic            r_bus_err;
   logic [2:0]      w_ex_alu_op;
   logic            w_timeout;

   alu_op_sel u_alu_op_sel (
      .i_opcode   (opcode),
      .i_funct3   (funct3),
      .i_funct7_5 (funct7_5),
      .o_alu_op   (w_ex_alu_op)
   );

   // The Nth consecutive unanswered wait cycle trips; mem_ready on that cycle still wins.
   assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ready &&
                      (r_wait_cnt == TO_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
         r_halted   <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_IF;
            S_IF: begin
               if (mem_ready) begin
                  r_state    <= S_ID;
                  r_wait_cnt <= '0;
               end else if (w_timeout) begin
                  r_state   <= S_HALT;
                  r_halted  <= 1'b1;
                  r_bus_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + TO_W'(1);
               end
            end
            S_ID: begin
               if (!is_exec_op(opcode)) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end else begin
                  r_state <= S_EX;
               end
            end
            S_EX: begin
               case (opcode)
                  OP_LOAD, OP_STORE: r_state <= S_MEM;
                  OP_BRANCH, OP_JAL: r_state <= S_IF;
                  default:           r_state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  r_state    <= (opcode == OP_LOAD) ? S_WB : S_IF;
                  r_wait_cnt <= '0;
               end else if (w_timeout) begin
                  r_state   <= S_HALT;
                  r_halted  <= 1'b1;
                  r_bus_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + TO_W'(1);
               end
            end
            S_WB:    r_state <= S_IF;
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode from the current state so an async reset clears them at once.
   always_comb begin
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      i_or_d       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = SRCA_OLDPC;
      alu_src_b    = SRCB_RS2;
      wb_sel       = WB_ALU;
      pc_src       = PCSRC_ALU;
      ALUControlOp = ConOP_ADD;
      case (r_state)
         S_IF: begin
            mem_read  = 1'b1;
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_ID: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_EX: begin
            ALUControlOp = w_ex_alu_op;
            case (opcode)
               OP_R: begin
                  alu_src_a = SRCA_RS1;
                  alu_src_b = SRCB_RS2;
               end
               OP_BRANCH: begin
                  alu_src_a = SRCA_RS1;
                  alu_src_b = SRCB_RS2;
                  pc_write  = Bcond;
                  pc_src    = PCSRC_ALUOUT;
               end
               OP_I, OP_LOAD, OP_STORE, OP_JALR: begin
                  alu_src_a = SRCA_RS1;
                  alu_src_b = SRCB_IMM;
               end
               OP_LUI:   alu_src_b = SRCB_IMM;
               OP_AUIPC: begin
                  alu_src_a = SRCA_OLDPC;
                  alu_src_b = SRCB_IMM;
               end
               // Link and jump in one cycle: ALUOut already holds OldPC+imm from ID.
               OP_JAL: begin
                  reg_write = 1'b1;
                  wb_sel    = WB_PC;
                  pc_write  = 1'b1;
                  pc_src    = PCSRC_ALUOUT;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            i_or_d = 1'b1;
            if (opcode == OP_LOAD) mem_read  = 1'b1;
            else                   mem_write = 1'b1;
         end
         S_WB: begin
            reg_write = 1'b1;
            if (opcode == OP_LOAD) begin
               wb_sel = WB_MDR;
            end else if (opcode == OP_JALR) begin
               wb_sel   = WB_PC;
               pc_write = 1'b1;
               pc_src   = PCSRC_ALUOUT;
            end
         end
         default: ;
      endcase
   end

   assign halted  = r_halted;
   assign bus_err = r_bus_err;

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instret_cnt;
   logic             w_ret_if;

   assign w_ret_if = (r_state == S_EX  && (opcode == OP_BRANCH || opcode == OP_JAL)) ||
                     (r_state == S_MEM && mem_ready && opcode == OP_STORE) ||
                     (r_state == S_WB);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if (r_state != S_IDLE && r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (w_ret_if) r_instret_cnt <= r_instret_cnt + CNT_W'(1);
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;
`else
   logic w_unused_cnt_w;
   assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: a phase-walk model of the controller checks every cycle's strobes.
// One instance waits forever on memory, the other uses MEM_TIMEOUT=4.
module tb_multicycle_ctrl_fsm;

   typedef enum int {P_IDLE, P_IF, P_ID, P_EX, P_MEM, P_WB, P_HALT} ph_t;

   typedef struct packed {
      logic       pcw, irw, iod, mrd, mwr, rw;
      logic [1:0] a, b, wb;
      logic       pcs;
      logic [2:0] aop;
      logic       hlt, berr;
   } out_t;

   localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011,
                          ST_OP = 7'b0100011, BR_OP = 7'b1100011, LUI_OP = 7'b0110111,
                          AUI_OP = 7'b0010111, JAL_OP = 7'b1101111, JALR_OP = 7'b1100111,
                          ECALL_OP = 7'b1110011, FENCE_OP = 7'b0001111;

   logic       clk, rst_m, rst_t, sel_t;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5, Bcond, mem_ready;

   logic       pcw_m, irw_m, iod_m, mrd_m, mwr_m, rw_m, pcs_m, hlt_m, berr_m;
   logic [1:0] a_m, b_m, wb_m;
   logic [2:0] aop_m;
   logic       pcw_t, irw_t, iod_t, mrd_t, mwr_t, rw_t, pcs_t, hlt_t, berr_t;
   logic [1:0] a_t, b_t, wb_t;
   logic [2:0] aop_t;
   out_t       obs_m, obs_t, obs;
`ifdef MC_PERF_CNT_EN
   logic [31:0] cyc_m, ins_m, cyc_t, ins_t;
`endif

   int          checks = 0, failures = 0;
   int unsigned m_cyc = 0, m_ins = 0;
   logic [6:0]  m_op = '0;
   logic [2:0]  m_f3 = '0;
   logic        m_f75 = 1'b0, m_berr = 1'b0;
   logic [6:0]  ops [9] = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, LUI_OP, AUI_OP, JAL_OP, JALR_OP};

   multicycle_ctrl_fsm #(.MEM_TIMEOUT(0), .CNT_W(32)) dut (
      .clk(clk), .reset_n(rst_m), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .Bcond(Bcond), .mem_ready(mem_ready), .pc_write(pcw_m), .ir_write(irw_m),
      .i_or_d(iod_m), .mem_read(mrd_m), .mem_write(mwr_m), .reg_write(rw_m),
      .alu_src_a(a_m), .alu_src_b(b_m), .wb_sel(wb_m), .pc_src(pcs_m),
      .ALUControlOp(aop_m), .halted(hlt_m), .bus_err(berr_m)
`ifdef MC_PERF_CNT_EN
      , .cycle_cnt(cyc_m), .instret_cnt(ins_m)
`endif
   );

   multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_to (
      .clk(clk), .reset_n(rst_t), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .Bcond(Bcond), .mem_ready(mem_ready), .pc_write(pcw_t), .ir_write(irw_t),
      .i_or_d(iod_t), .mem_read(mrd_t), .mem_write(mwr_t), .reg_write(rw_t),
      .alu_src_a(a_t), .alu_src_b(b_t), .wb_sel(wb_t), .pc_src(pcs_t),
      .ALUControlOp(aop_t), .halted(hlt_t), .bus_err(berr_t)
`ifdef MC_PERF_CNT_EN
      , .cycle_cnt(cyc_t), .instret_cnt(ins_t)
`endif
   );

   assign obs_m = {pcw_m, irw_m, iod_m, mrd_m, mwr_m, rw_m, a_m, b_m, wb_m, pcs_m, aop_m, hlt_m, berr_m};
   assign obs_t = {pcw_t, irw_t, iod_t, mrd_t, mwr_t, rw_t, a_t, b_t, wb_t, pcs_t, aop_t, hlt_t, berr_t};
   assign obs   = sel_t ? obs_t : obs_m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic legal(input logic [6:0] op);
      foreach (ops[i]) if (ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Expected strobes for a phase of the current instruction, straight from the control table.
   function automatic out_t model_out(input ph_t ph, input logic mr, input logic bc);
      out_t e = '0;
      case (ph)
         P_IF:  begin e.mrd = 1; e.a = 3; e.b = 2; e.irw = mr; e.pcw = mr; end
         P_ID:  begin e.a = 0; e.b = 1; end
         P_EX: begin
            if (m_op == R_OP)         begin e.aop = m_f75 ? 3'b101 : 3'b001; e.a = 1; e.b = 0; end
            else if (m_op == I_OP)    begin e.aop = (m_f3 == 3'd5 && m_f75) ? 3'b110 : 3'b010; e.a = 1; e.b = 1; end
            else if (m_op == LD_OP || m_op == ST_OP || m_op == JALR_OP) begin e.a = 1; e.b = 1; end
            else if (m_op == BR_OP)   begin e.aop = 3'b011; e.a = 1; e.pcw = bc; e.pcs = 1; end
            else if (m_op == LUI_OP)  begin e.aop = 3'b111; e.b = 1; end
            else if (m_op == AUI_OP)  begin e.b = 1; end
            else if (m_op == JAL_OP)  begin e.rw = 1; e.wb = 2; e.pcw = 1; e.pcs = 1; end
         end
         P_MEM: begin e.iod = 1; if (m_op == LD_OP) e.mrd = 1; else e.mwr = 1; end
         P_WB: begin
            e.rw = 1;
            if (m_op == LD_OP) e.wb = 1;
            if (m_op == JALR_OP) begin e.wb = 2; e.pcw = 1; e.pcs = 1; end
         end
         P_HALT: begin e.hlt = 1; e.berr = m_berr; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle: drive inputs on the falling edge, check outputs 1ns later.
   task automatic step(input ph_t ph, input logic mr, input logic bc, input bit junk);
      @(negedge clk);
      if (junk) begin
         opcode = 7'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
      end else begin
         opcode = m_op; funct3 = m_f3; funct7_5 = m_f75;
      end
      mem_ready = mr; Bcond = bc;
      #1;
      chk(ph.name(), 32'(obs), 32'(model_out(ph, mr, bc)));
`ifdef MC_PERF_CNT_EN
      chk("cycle_cnt", sel_t ? cyc_t : cyc_m, m_cyc);
      chk("instret_cnt", sel_t ? ins_t : ins_m, m_ins);
`endif
      if (ph != P_IDLE && ph != P_HALT) m_cyc++;
   endtask

   task automatic do_reset(input bit tsel);
      @(negedge clk);
      rst_m = 1'b0; rst_t = 1'b0; sel_t = tsel;
      #1;
      chk("reset", 32'(obs), 32'd0);
      m_cyc = 0; m_ins = 0; m_berr = 1'b0;
      #2;
      if (tsel) rst_t = 1'b1; else rst_m = 1'b1;
      #1;
      chk("idle", 32'(obs), 32'd0);
   endtask

   // Walk one instruction through its phases; returns after ID for halting opcodes.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                            input logic bc, input int ifw, input int memw);
      m_op = op; m_f3 = f3; m_f75 = f75;
      for (int w = 0; w <= ifw; w++) step(P_IF, logic'(w == ifw), 1'($urandom), 1'b1);
      step(P_ID, 1'($urandom), 1'($urandom), 1'b0);
      if (!legal(op)) return;
      step(P_EX, 1'($urandom), bc, 1'b0);
      if (op == LD_OP || op == ST_OP) begin
         for (int w = 0; w <= memw; w++) step(P_MEM, logic'(w == memw), 1'($urandom), 1'b0);
         if (op == LD_OP) step(P_WB, 1'($urandom), 1'($urandom), 1'b0);
      end else if (op != BR_OP && op != JAL_OP) begin
         step(P_WB, 1'($urandom), 1'($urandom), 1'b0);
      end
      m_ins++;
   endtask

   initial begin
      rst_m = 1'b0; rst_t = 1'b0; sel_t = 1'b0;
      opcode = '0; funct3 = '0; funct7_5 = 1'b0; Bcond = 1'b0; mem_ready = 1'b0;
      #1;
      chk("por", 32'(obs), 32'd0);

      // Directed: SUB, branches, waited load, shifts, upper-immediates, jumps, store.
      do_reset(1'b0);
      run_instr(R_OP,   3'd0, 1'b1, 1'b0, 0, 0);
      run_instr(BR_OP,  3'd0, 1'b0, 1'b1, 0, 0);
      run_instr(BR_OP,  3'd0, 1'b0, 1'b0, 0, 0);
      run_instr(LD_OP,  3'd2, 1'b0, 1'b0, 0, 3);
      run_instr(I_OP,   3'd5, 1'b1, 1'b0, 0, 0);
      run_instr(I_OP,   3'd5, 1'b0, 1'b0, 0, 0);
      run_instr(I_OP,   3'd0, 1'b1, 1'b0, 0, 0);
      run_instr(LUI_OP, 3'd3, 1'b1, 1'b0, 1, 0);
      run_instr(JAL_OP, 3'd0, 1'b0, 1'b0, 0, 0);
      run_instr(AUI_OP, 3'd1, 1'b0, 1'b0, 2, 0);
      run_instr(JALR_OP,3'd0, 1'b0, 1'b0, 0, 0);
      run_instr(ST_OP,  3'd2, 1'b0, 1'b0, 1, 2);

      // Random instruction mix with random memory waits.
      for (int n = 0; n < 40; n++)
         run_instr(ops[$urandom_range(0, 8)], 3'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3));

      // Three back-to-back ADDIs from reset.
      do_reset(1'b0);
      for (int n = 0; n < 3; n++) run_instr(I_OP, 3'd0, 1'b0, 1'b0, 0, 0);
`ifdef MC_PERF_CNT_EN
      @(posedge clk); #1;
      chk("cyc_3addi", cyc_m, 32'd12);
      chk("ins_3addi", ins_m, 32'd3);
`endif

      // ECALL halts; halted is sticky and strobes stay quiet.
      run_instr(ECALL_OP, 3'd0, 1'b0, 1'b0, 0, 0);
      for (int n = 0; n < 10; n++) step(P_HALT, 1'($urandom), 1'($urandom), 1'b1);
      chk("halted", 32'(hlt_m), 32'd1);

      // Reset in the middle of a waited load clears outputs with no clock edge.
      do_reset(1'b0);
      m_op = LD_OP; m_f3 = 3'd2; m_f75 = 1'b0;
      step(P_IF, 1'b1, 1'b0, 1'b1);
      step(P_ID, 1'b0, 1'b0, 1'b0);
      step(P_EX, 1'b0, 1'b0, 1'b0);
      step(P_MEM, 1'b0, 1'b0, 1'b0);
      step(P_MEM, 1'b0, 1'b0, 1'b0);
      #2; rst_m = 1'b0; #1;
      chk("rst_mid_mem", 32'(obs), 32'd0);

      // Unknown opcode halts too.
      do_reset(1'b0);
      run_instr(FENCE_OP, 3'd0, 1'b0, 1'b0, 0, 0);
      for (int n = 0; n < 3; n++) step(P_HALT, 1'($urandom), 1'($urandom), 1'b0);

      // MEM_TIMEOUT=4: ready on the 4th wait cycle still completes.
      do_reset(1'b1);
      run_instr(I_OP,  3'd0, 1'b0, 1'b0, 3, 0);
      run_instr(LD_OP, 3'd2, 1'b0, 1'b0, 0, 3);
      m_op = ST_OP; m_f3 = 3'd2; m_f75 = 1'b0;
      step(P_IF, 1'b1, 1'b0, 1'b1);
      step(P_ID, 1'b0, 1'b0, 1'b0);
      step(P_EX, 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 4; w++) step(P_MEM, 1'b0, 1'($urandom), 1'b0);
      m_berr = 1'b1;
      for (int n = 0; n < 3; n++) step(P_HALT, 1'($urandom), 1'($urandom), 1'b0);
      chk("bus_err_mem", 32'(berr_t), 32'd1);

      do_reset(1'b1);
      for (int w = 0; w < 4; w++) step(P_IF, 1'b0, 1'($urandom), 1'b1);
      m_berr = 1'b1;
      for (int n = 0; n < 3; n++) step(P_HALT, 1'($urandom), 1'($urandom), 1'b1);
      chk("bus_err_if", 32'(berr_t), 32'd1);
      chk("halted_if", 32'(hlt_t), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
